// File: rtl/posit_decode_pipe.sv
// Two-stage pipelined posit field decoder: stage 1 takes the magnitude and flags
// zero/NaR, stage 2 measures the regime run, strips it and splits exponent/fraction.
module posit_decode_pipe #(
    parameter int N  = 8,
    parameter int ES = 3,
    parameter int RS = $clog2(N)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        In,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                Sign,
    output logic signed [RS:0]  Regime,
    output logic [ES-1:0]       Exponent,
    output logic [N-ES-1:0]     Mantissa,
    output logic                Zero,
    output logic                NaR,
    output logic                out_valid,
    input  logic                out_ready
);

    logic s1_load, s2_load;

    logic         s1_valid_q, s1_sign_q, s1_zero_q, s1_nar_q;
    logic [N-1:0] s1_abs_q;

    logic                s2_valid_q, sign_q, zero_q, nar_q;
    logic signed [RS:0]  regime_q;
    logic [ES-1:0]       exp_q;
    logic [N-ES-1:0]     mant_q;

    logic                sign_d, zero_d, nar_d;
    logic signed [RS:0]  regime_d;
    logic [ES-1:0]       exp_d;
    logic [N-ES-1:0]     mant_d;

    logic [N-2:0]  remain, shifted;
    logic          rc, in_run;
    logic [RS-1:0] run_len;
    logic [RS:0]   run_ext, shamt;

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    // NOTE: data registers load only with a valid item so bubbles never disturb held outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_nar_q   <= 1'b0;
            s1_abs_q   <= '0;
        end else if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q <= In[N-1];
                s1_abs_q  <= In[N-1] ? -In : In;
                s1_zero_q <= (In == '0);
                s1_nar_q  <= (In == {1'b1, {(N-1){1'b0}}});
            end
        end
    end

    // Regime run length: leading bits of remain equal to its top bit, capped at N-1.
    always_comb begin
        remain  = s1_abs_q[N-2:0];
        rc      = remain[N-2];
        run_len = '0;
        in_run  = 1'b1;
        for (int i = N - 2; i >= 0; i--) begin
            if (in_run && (remain[i] == rc)) begin
                run_len = run_len + RS'(1);
            end else begin
                in_run = 1'b0;
            end
        end
        run_ext = {1'b0, run_len};
        shamt   = run_ext + (RS+1)'(1);
        shifted = remain << shamt;
    end

    always_comb begin
        sign_d   = s1_sign_q;
        zero_d   = s1_zero_q;
        nar_d    = s1_nar_q;
        regime_d = rc ? $signed(run_ext - (RS+1)'(1)) : -$signed(run_ext);
        exp_d    = shifted[N-2 -: ES];
        mant_d   = {1'b1, shifted[N-2-ES:0]};
        if (s1_zero_q || s1_nar_q) begin
            regime_d = '0;
            exp_d    = '0;
            mant_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            sign_q     <= 1'b0;
            regime_q   <= '0;
            exp_q      <= '0;
            mant_q     <= '0;
            zero_q     <= 1'b0;
            nar_q      <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sign_q   <= sign_d;
                regime_q <= regime_d;
                exp_q    <= exp_d;
                mant_q   <= mant_d;
                zero_q   <= zero_d;
                nar_q    <= nar_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign Sign      = sign_q;
    assign Regime    = regime_q;
    assign Exponent  = exp_q;
    assign Mantissa  = mant_q;
    assign Zero      = zero_q;
    assign NaR       = nar_q;

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Self-checking bench for posit_decode_pipe: directed corner words plus randomized
// handshake traffic, scored against an arithmetic posit decoding model.
module tb_posit_decode_pipe;

    localparam int N  = 8;
    localparam int ES = 3;
    localparam int RS = $clog2(N);

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        In;
    logic                in_valid;
    logic                in_ready;
    logic                Sign;
    logic signed [RS:0]  Regime;
    logic [ES-1:0]       Exponent;
    logic [N-ES-1:0]     Mantissa;
    logic                Zero;
    logic                NaR;
    logic                out_valid;
    logic                out_ready;

    posit_decode_pipe #(.N(N), .ES(ES), .RS(RS)) dut (
        .clk       (clk),
        .reset     (reset),
        .In        (In),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Sign      (Sign),
        .Regime    (Regime),
        .Exponent  (Exponent),
        .Mantissa  (Mantissa),
        .Zero      (Zero),
        .NaR       (NaR),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sign;
        int regime;
        int expo;
        int mant;
        int zero;
        int nar;
        int acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_check = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input int got, input int want);
        n_check++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    // Posit decoding from the number format itself: magnitude, regime run,
    // then whatever bits remain are exponent first and fraction after.
    function automatic exp_t decode(input logic [N-1:0] w);
        exp_t e;
        int a, rc, m, rem, rest, fb, fr;
        e = '{default: 0};
        if (w == 0) begin
            e.zero = 1;
            return e;
        end
        if (int'(w) == (1 << (N-1))) begin
            e.nar  = 1;
            e.sign = 1;
            return e;
        end
        e.sign = int'(w[N-1]);
        a  = w[N-1] ? (1 << N) - int'(w) : int'(w);
        rc = (a >> (N-2)) & 1;
        m  = 0;
        while (m < N-1 && ((a >> (N-2-m)) & 1) == rc) m++;
        e.regime = rc ? m - 1 : -m;
        rem = N - 2 - m;
        if (rem < 0) rem = 0;
        rest = a & ((1 << rem) - 1);
        fb   = N - 1 - ES;
        if (rem >= ES) begin
            fr     = rem - ES;
            e.expo = rest >> fr;
            e.mant = (1 << fb) | ((rest & ((1 << fr) - 1)) << (fb - fr));
        end else begin
            e.expo = rest << (ES - rem);
            e.mant = 1 << fb;
        end
        return e;
    endfunction

    // One clock cycle: drive, check at the falling edge, then advance the model.
    task automatic step(input logic [N-1:0] w, input logic v, input logic r);
        exp_t e, h;
        int   exp_ready, exp_ov;
        logic acc, fire;
        In        = w;
        in_valid  = v;
        out_ready = r;
        @(negedge clk);
        exp_ready = (sb.size() == 2 && !r) ? 0 : 1;
        exp_ov    = (sb.size() > 0 && (cyc - sb[0].acc_cyc) >= 2) ? 1 : 0;
        check("in_ready", int'(in_ready), exp_ready);
        check("out_valid", int'(out_valid), exp_ov);
        if (exp_ov == 1) begin
            h = sb[0];
            check("Sign", int'(Sign), h.sign);
            check("Regime", int'(Regime), h.regime);
            check("Exponent", int'(Exponent), h.expo);
            check("Mantissa", int'(Mantissa), h.mant);
            check("Zero", int'(Zero), h.zero);
            check("NaR", int'(NaR), h.nar);
        end
        acc  = v && (exp_ready == 1);
        fire = (exp_ov == 1) && r;
        if (acc) begin
            e = decode(w);
            e.acc_cyc = cyc;
        end
        @(posedge clk);
        cyc++;
        if (fire) void'(sb.pop_front());
        if (acc) sb.push_back(e);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_fields"}, int'({Sign, Regime, Exponent, Mantissa, Zero, NaR}), 0);
        check({tag, "_in_ready"}, int'(in_ready), 1);
    endtask

    logic [N-1:0] dir_words [7];
    logic [N-1:0] corner [6];

    initial begin
        dir_words = '{8'h40, 8'h5A, 8'hA6, 8'h7F, 8'h01, 8'h00, 8'h80};
        corner    = '{8'h00, 8'h80, 8'h7F, 8'h01, 8'hFF, 8'h81};

        reset     = 1'b1;
        In        = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        reset = 1'b0;

        // Test-plan words back-to-back, then drain.
        foreach (dir_words[i]) step(dir_words[i], 1'b1, 1'b1);
        repeat (3) step('0, 1'b0, 1'b1);

        // Stall: out_ready drops after the first accept; 7F must wait.
        step(8'h40, 1'b1, 1'b1);
        step(8'h5A, 1'b1, 1'b0);
        repeat (4) step(8'h7F, 1'b1, 1'b0);
        step(8'h7F, 1'b1, 1'b1);
        repeat (4) step('0, 1'b0, 1'b1);

        // Reset with two items in flight.
        step(8'h40, 1'b1, 1'b1);
        step(8'h5A, 1'b1, 1'b1);
        reset = 1'b1;
        #1;
        check_cleared("midreset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        step(8'h7F, 1'b1, 1'b1);
        repeat (3) step('0, 1'b0, 1'b1);

        // Random traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] w;
            w = N'($urandom);
            if ($urandom_range(0, 7) == 0) w = corner[$urandom_range(0, 5)];
            step(w, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6));
        end
        repeat (4) step('0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
